// File: rtl/alu_reservation_station_if.sv
// Issue, result-bus and dispatch signals of the ALU reservation station.
// The issuer and the result buses drive the master side; the station is the slave side.
interface alu_reservation_station_if #(
  parameter int TAG_W  = 5,
  parameter int OP_W   = 6,
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic              issue_qj_busy;
  logic [TAG_W-1:0]  issue_qj;
  logic [DATA_W-1:0] issue_vj;
  logic              issue_qk_busy;
  logic [TAG_W-1:0]  issue_qk;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_rob;
  logic              rs_full;

  logic              alu_cdb_valid;
  logic [TAG_W-1:0]  alu_cdb_tag;
  logic [DATA_W-1:0] alu_cdb_val;
  logic              lsb_cdb_valid;
  logic [TAG_W-1:0]  lsb_cdb_tag;
  logic [DATA_W-1:0] lsb_cdb_val;

  logic              alu_status;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_rs1;
  logic [DATA_W-1:0] alu_rs2;
  logic [TAG_W-1:0]  alu_rob;

  modport master (
    output issue_valid, issue_op, issue_qj_busy, issue_qj, issue_vj,
           issue_qk_busy, issue_qk, issue_vk, issue_rob,
           alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
           lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val,
    input  rs_full, alu_status, alu_op, alu_rs1, alu_rs2, alu_rob
  );

  modport slave (
    input  issue_valid, issue_op, issue_qj_busy, issue_qj, issue_vj,
           issue_qk_busy, issue_qk, issue_vk, issue_rob,
           alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
           lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val,
    output rs_full, alu_status, alu_op, alu_rs1, alu_rs2, alu_rob
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers issued ALU ops until both operands are known,
// snoops the ALU and LSB result buses by ROB tag, dispatches one ready op per cycle.
module alu_reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int TAG_W   = 5,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clear,
  alu_reservation_station_if.slave    bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qj_busy;
  logic [RS_SIZE-1:0] r_qk_busy;
  logic [OP_W-1:0]    r_op  [RS_SIZE];
  logic [DATA_W-1:0]  r_vj  [RS_SIZE];
  logic [DATA_W-1:0]  r_vk  [RS_SIZE];
  logic [TAG_W-1:0]   r_qj  [RS_SIZE];
  logic [TAG_W-1:0]   r_qk  [RS_SIZE];
  logic [TAG_W-1:0]   r_rob [RS_SIZE];

  logic               r_alu_status;
  logic [OP_W-1:0]    r_alu_op;
  logic [DATA_W-1:0]  r_alu_rs1;
  logic [DATA_W-1:0]  r_alu_rs2;
  logic [TAG_W-1:0]   r_alu_rob;

  logic               w_full;
  logic               w_free_found;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_rdy_found;
  logic [IDX_W-1:0]   w_rdy_idx;
  logic               w_issue_en;
  logic [DATA_W-1:0]  w_new_vj;
  logic [DATA_W-1:0]  w_new_vk;
  logic               w_new_qj_busy;
  logic               w_new_qk_busy;

  assign w_full     = &r_busy;
  assign w_issue_en = bus.issue_valid & ~w_full & w_free_found;

  // Descending scan so the lowest index is the one left selected.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_rdy_found  = 1'b0;
    w_rdy_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i]) begin
        w_rdy_found = 1'b1;
        w_rdy_idx   = IDX_W'(i);
      end
    end
  end

  // A result broadcast in the issue cycle is captured at write, or the wakeup is lost.
  always_comb begin
    w_new_vj      = bus.issue_vj;
    w_new_qj_busy = bus.issue_qj_busy;
    w_new_vk      = bus.issue_vk;
    w_new_qk_busy = bus.issue_qk_busy;
    if (bus.issue_qj_busy) begin
      if (bus.alu_cdb_valid && (bus.alu_cdb_tag == bus.issue_qj)) begin
        w_new_vj      = bus.alu_cdb_val;
        w_new_qj_busy = 1'b0;
      end else if (bus.lsb_cdb_valid && (bus.lsb_cdb_tag == bus.issue_qj)) begin
        w_new_vj      = bus.lsb_cdb_val;
        w_new_qj_busy = 1'b0;
      end
    end
    if (bus.issue_qk_busy) begin
      if (bus.alu_cdb_valid && (bus.alu_cdb_tag == bus.issue_qk)) begin
        w_new_vk      = bus.alu_cdb_val;
        w_new_qk_busy = 1'b0;
      end else if (bus.lsb_cdb_valid && (bus.lsb_cdb_tag == bus.issue_qk)) begin
        w_new_vk      = bus.lsb_cdb_val;
        w_new_qk_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy       <= '0;
      r_qj_busy    <= '0;
      r_qk_busy    <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]  <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
        r_rob[i] <= '0;
      end
      r_alu_status <= 1'b0;
      r_alu_op     <= '0;
      r_alu_rs1    <= '0;
      r_alu_rs2    <= '0;
      r_alu_rob    <= '0;
    end else if (clear) begin
      r_busy       <= '0;
      r_alu_status <= 1'b0;
    end else if (!rdy_in) begin
      r_alu_status <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_qj_busy[i]) begin
          if (bus.alu_cdb_valid && (bus.alu_cdb_tag == r_qj[i])) begin
            r_vj[i]      <= bus.alu_cdb_val;
            r_qj_busy[i] <= 1'b0;
          end else if (bus.lsb_cdb_valid && (bus.lsb_cdb_tag == r_qj[i])) begin
            r_vj[i]      <= bus.lsb_cdb_val;
            r_qj_busy[i] <= 1'b0;
          end
        end
        if (r_busy[i] && r_qk_busy[i]) begin
          if (bus.alu_cdb_valid && (bus.alu_cdb_tag == r_qk[i])) begin
            r_vk[i]      <= bus.alu_cdb_val;
            r_qk_busy[i] <= 1'b0;
          end else if (bus.lsb_cdb_valid && (bus.lsb_cdb_tag == r_qk[i])) begin
            r_vk[i]      <= bus.lsb_cdb_val;
            r_qk_busy[i] <= 1'b0;
          end
        end
      end

      if (w_rdy_found) begin
        r_alu_status      <= 1'b1;
        r_alu_op          <= r_op[w_rdy_idx];
        r_alu_rs1         <= r_vj[w_rdy_idx];
        r_alu_rs2         <= r_vk[w_rdy_idx];
        r_alu_rob         <= r_rob[w_rdy_idx];
        r_busy[w_rdy_idx] <= 1'b0;
      end else begin
        r_alu_status <= 1'b0;
      end

      // The free slot is never the dispatched one, so these writes do not collide.
      if (w_issue_en) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_op[w_free_idx]      <= bus.issue_op;
        r_vj[w_free_idx]      <= w_new_vj;
        r_vk[w_free_idx]      <= w_new_vk;
        r_qj[w_free_idx]      <= bus.issue_qj;
        r_qk[w_free_idx]      <= bus.issue_qk;
        r_qj_busy[w_free_idx] <= w_new_qj_busy;
        r_qk_busy[w_free_idx] <= w_new_qk_busy;
        r_rob[w_free_idx]     <= bus.issue_rob;
      end
    end
  end

  assign bus.rs_full    = w_full;
  assign bus.alu_status = r_alu_status;
  assign bus.alu_op     = r_alu_op;
  assign bus.alu_rs1    = r_alu_rs1;
  assign bus.alu_rs2    = r_alu_rs2;
  assign bus.alu_rob    = r_alu_rob;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: dispatches are checked against a queue of
// expected ops filled as stimulus is driven, plus direct timing/status checks.
module tb_alu_reservation_station;
  localparam int RS_SIZE = 16;
  localparam int TAG_W   = 5;
  localparam int OP_W    = 6;
  localparam int DATA_W  = 32;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic clear  = 1'b0;

  always #5 clk_in = ~clk_in;

  alu_reservation_station_if #(.TAG_W(TAG_W), .OP_W(OP_W), .DATA_W(DATA_W)) bus ();

  alu_reservation_station #(
    .RS_SIZE(RS_SIZE), .TAG_W(TAG_W), .OP_W(OP_W), .DATA_W(DATA_W)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [TAG_W-1:0]  rob;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    bus.issue_valid   = 1'b0;
    bus.issue_op      = '0;
    bus.issue_qj_busy = 1'b0;
    bus.issue_qj      = '0;
    bus.issue_vj      = '0;
    bus.issue_qk_busy = 1'b0;
    bus.issue_qk      = '0;
    bus.issue_vk      = '0;
    bus.issue_rob     = '0;
    bus.alu_cdb_valid = 1'b0;
    bus.alu_cdb_tag   = '0;
    bus.alu_cdb_val   = '0;
    bus.lsb_cdb_valid = 1'b0;
    bus.lsb_cdb_tag   = '0;
    bus.lsb_cdb_val   = '0;
  endtask

  task automatic issue_set(input logic [OP_W-1:0] op,
                           input logic qjb, input logic [TAG_W-1:0] qj, input logic [DATA_W-1:0] vj,
                           input logic qkb, input logic [TAG_W-1:0] qk, input logic [DATA_W-1:0] vk,
                           input logic [TAG_W-1:0] rob);
    bus.issue_valid   = 1'b1;
    bus.issue_op      = op;
    bus.issue_qj_busy = qjb;
    bus.issue_qj      = qj;
    bus.issue_vj      = vj;
    bus.issue_qk_busy = qkb;
    bus.issue_qk      = qk;
    bus.issue_vk      = vk;
    bus.issue_rob     = rob;
  endtask

  task automatic expect_disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] rs1,
                             input logic [DATA_W-1:0] rs2, input logic [TAG_W-1:0] rob);
    exp_t e;
    e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rob = rob;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    tick();
    chk_val(tag, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (!rst_in && bus.alu_status) begin
      if (sb.size() == 0) begin
        chk_val("unexpected_dispatch_rob", 64'(bus.alu_rob), 64'h3f);
      end else begin
        e = sb.pop_front();
        chk_val("disp_op",  64'(bus.alu_op),  64'(e.op));
        chk_val("disp_rs1", 64'(bus.alu_rs1), 64'(e.rs1));
        chk_val("disp_rs2", 64'(bus.alu_rs2), 64'(e.rs2));
        chk_val("disp_rob", 64'(bus.alu_rob), 64'(e.rob));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    #1 rst_in = 1'b1;
    #2;
    chk_val("rst_status", 64'(bus.alu_status), 64'd0);
    chk_val("rst_op",     64'(bus.alu_op),     64'd0);
    chk_val("rst_rs1",    64'(bus.alu_rs1),    64'd0);
    chk_val("rst_rs2",    64'(bus.alu_rs2),    64'd0);
    chk_val("rst_rob",    64'(bus.alu_rob),    64'd0);
    chk_val("rst_full",   64'(bus.rs_full),    64'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // 1: ready ADD dispatches two cycles after issue, status drops the cycle after
    issue_set(6'd1, 1'b0, '0, 32'd5, 1'b0, '0, 32'd7, 5'd3);
    expect_disp(6'd1, 32'd5, 32'd7, 5'd3);
    tick();
    drive_idle();
    chk_val("t1_status_early", 64'(bus.alu_status), 64'd0);
    tick();
    chk_val("t1_status_lat", 64'(bus.alu_status), 64'd1);
    tick();
    chk_val("t1_status_drop", 64'(bus.alu_status), 64'd0);

    // 2: SUB waits on tag 4, woken by ALU bus
    issue_set(6'd2, 1'b1, 5'd4, 32'd0, 1'b0, '0, 32'd1, 5'd5);
    expect_disp(6'd2, 32'd10, 32'd1, 5'd5);
    tick();
    drive_idle();
    tick();
    tick();
    chk_val("t2_pending", 64'(bus.alu_status), 64'd0);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_tag = 5'd4; bus.alu_cdb_val = 32'd10;
    tick();
    drive_idle();
    chk_val("t2_wake_edge", 64'(bus.alu_status), 64'd0);
    tick();
    chk_val("t2_dispatch", 64'(bus.alu_status), 64'd1);
    tick();

    // 3: operand resolved by the LSB bus in the issue cycle itself
    issue_set(6'd3, 1'b0, '0, 32'd2, 1'b1, 5'd6, 32'd0, 5'd7);
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_tag = 5'd6; bus.lsb_cdb_val = 32'hFFFF_FFFF;
    expect_disp(6'd3, 32'd2, 32'hFFFF_FFFF, 5'd7);
    tick();
    drive_idle();
    drain("t3_drain", 10);

    // 4: fill all entries pending, overflow issue ignored, one wakeup frees a slot
    for (int i = 0; i < RS_SIZE; i++) begin
      if (i == RS_SIZE - 1) chk_val("t4_not_full_15", 64'(bus.rs_full), 64'd0);
      issue_set(6'd4, 1'b1, 5'(i + 10), 32'd0, 1'b0, '0, 32'h40 + 32'(i), 5'(i));
      tick();
    end
    drive_idle();
    chk_val("t4_full", 64'(bus.rs_full), 64'd1);
    issue_set(6'd5, 1'b0, '0, 32'd9, 1'b0, '0, 32'd9, 5'd31);
    tick();
    drive_idle();
    chk_val("t4_full_hold", 64'(bus.rs_full), 64'd1);
    tick();
    chk_val("t4_no_overflow", 64'(bus.alu_status), 64'd0);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_tag = 5'd10; bus.alu_cdb_val = 32'h100;
    expect_disp(6'd4, 32'h100, 32'h40, 5'd0);
    tick();
    drive_idle();
    chk_val("t4_full_at_wake", 64'(bus.rs_full), 64'd1);
    tick();
    chk_val("t4_dispatch", 64'(bus.alu_status), 64'd1);
    chk_val("t4_full_freed", 64'(bus.rs_full), 64'd0);
    tick();

    // 6a: flush with busy entries; issue and bus traffic in the flush cycle ignored
    clear = 1'b1;
    issue_set(6'd7, 1'b0, '0, 32'd1, 1'b0, '0, 32'd1, 5'd30);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_tag = 5'd11; bus.alu_cdb_val = 32'h5;
    tick();
    clear = 1'b0;
    drive_idle();
    chk_val("t6_clear_status", 64'(bus.alu_status), 64'd0);
    chk_val("t6_clear_full",   64'(bus.rs_full),    64'd0);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_tag = 5'd12; bus.alu_cdb_val = 32'h6;
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_tag = 5'd13; bus.lsb_cdb_val = 32'h7;
    tick();
    drive_idle();
    tick();
    tick();
    chk_val("t6_no_dispatch", 64'(bus.alu_status), 64'd0);

    // 5: three entries become ready together, rdy_in low for two cycles, then in-order drain
    for (int i = 0; i < 3; i++) begin
      issue_set(6'(8 + i), 1'b0, '0, 32'h11 * 32'(i + 1), 1'b1, 5'd20, 32'd0, 5'(11 + i));
      tick();
    end
    drive_idle();
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_tag = 5'd20; bus.alu_cdb_val = 32'hABC;
    tick();
    drive_idle();
    rdy_in = 1'b0;
    tick();
    chk_val("t5_frozen_1", 64'(bus.alu_status), 64'd0);
    tick();
    chk_val("t5_frozen_2", 64'(bus.alu_status), 64'd0);
    for (int i = 0; i < 3; i++) expect_disp(6'(8 + i), 32'h11 * 32'(i + 1), 32'hABC, 5'(11 + i));
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_val("t5_back_to_back", 64'(bus.alu_status), 64'd1);
    end
    tick();
    chk_val("t5_done", 64'(bus.alu_status), 64'd0);
    chk_val("t5_sb_empty", 64'(sb.size()), 64'd0);

    // 6b: asynchronous reset mid-cycle while a dispatch is showing
    issue_set(6'd12, 1'b1, 5'd3, 32'd0, 1'b0, '0, 32'd4, 5'd21);
    tick();
    issue_set(6'd13, 1'b0, '0, 32'd1, 1'b0, '0, 32'd2, 5'd9);
    tick();
    drive_idle();
    tick();
    chk_val("t6_pre_rst_status", 64'(bus.alu_status), 64'd1);
    #2 rst_in = 1'b1;
    #1;
    chk_val("t6_rst_status", 64'(bus.alu_status), 64'd0);
    chk_val("t6_rst_op",     64'(bus.alu_op),     64'd0);
    chk_val("t6_rst_rs1",    64'(bus.alu_rs1),    64'd0);
    chk_val("t6_rst_rob",    64'(bus.alu_rob),    64'd0);
    tick();
    rst_in = 1'b0;
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_tag = 5'd3; bus.alu_cdb_val = 32'h77;
    tick();
    drive_idle();
    tick();
    tick();
    chk_val("t6_post_rst_idle", 64'(bus.alu_status), 64'd0);
    chk_val("t6_post_rst_full", 64'(bus.rs_full),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
